// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath (master) and the hazard controller (slave).
// There is no valid/ready handshake: every signal is level-sensitive and meaningful each cycle.
interface pipeline_hazard_ctrl_if;
  logic [4:0] ifid_rs1;
  logic [4:0] ifid_rs2;
  logic       ifid_uses_rs2;
  logic [4:0] idex_rd;
  logic [2:0] idex_mem;
  logic       branch_taken;
  logic       dmem_busy;
  logic       pc_write;
  logic       ifid_write;
  logic       ifid_flush;
  logic       idex_bubble;
  logic       idex_hold;
  logic       exmem_hold;

  modport master (
    output ifid_rs1, ifid_rs2, ifid_uses_rs2, idex_rd, idex_mem, branch_taken, dmem_busy,
    input  pc_write, ifid_write, ifid_flush, idex_bubble, idex_hold, exmem_hold
  );

  modport slave (
    input  ifid_rs1, ifid_rs2, ifid_uses_rs2, idex_rd, idex_mem, branch_taken, dmem_busy,
    output pc_write, ifid_write, ifid_flush, idex_bubble, idex_hold, exmem_hold
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, branch flushes, memory-busy freeze,
// plus saturating stall/flush performance counters.
module pipeline_hazard_ctrl #(
  parameter int LU_BUBBLES   = 1,
  parameter int FLUSH_CYCLES = 1,
  parameter int CW           = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pipeline_hazard_ctrl_if.slave hz,
  output logic [1:0]            ctrl_state,
  output logic [CW-1:0]         stall_cnt,
  output logic [CW-1:0]         flush_cnt
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    LU_STALL = 2'b01,
    FLUSH    = 2'b10
  } state_t;

  localparam logic [2:0] LU_REM = 3'(LU_BUBBLES - 1);
  localparam logic [2:0] FL_REM = 3'(FLUSH_CYCLES - 1);

  state_t     state, state_nx;
  logic [2:0] rem, rem_nx;
  logic       lu_hz;

  assign lu_hz = hz.idex_mem[2] && (hz.idex_rd != 5'd0) &&
                 ((hz.idex_rd == hz.ifid_rs1) ||
                  (hz.ifid_uses_rs2 && (hz.idex_rd == hz.ifid_rs2)));

  assign ctrl_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      rem   <= 3'd0;
    end else begin
      state <= state_nx;
      rem   <= rem_nx;
    end
  end

  // A freeze leaves state and rem untouched so the interrupted event resumes intact.
  always_comb begin
    state_nx = state;
    rem_nx   = rem;
    if (!hz.dmem_busy) begin
      case (state)
        RUN: begin
          if (hz.branch_taken) begin
            if (FLUSH_CYCLES > 1) begin
              state_nx = FLUSH;
              rem_nx   = FL_REM;
            end
          end else if (lu_hz && (LU_BUBBLES > 1)) begin
            state_nx = LU_STALL;
            rem_nx   = LU_REM;
          end
        end
        LU_STALL: begin
          if (hz.branch_taken) begin
            if (FLUSH_CYCLES > 1) begin
              state_nx = FLUSH;
              rem_nx   = FL_REM;
            end else begin
              state_nx = RUN;
              rem_nx   = 3'd0;
            end
          end else if (rem <= 3'd1) begin
            state_nx = RUN;
            rem_nx   = 3'd0;
          end else begin
            rem_nx = rem - 3'd1;
          end
        end
        FLUSH: begin
          if (rem <= 3'd1) begin
            state_nx = RUN;
            rem_nx   = 3'd0;
          end else begin
            rem_nx = rem - 3'd1;
          end
        end
        default: begin
          state_nx = RUN;
          rem_nx   = 3'd0;
        end
      endcase
    end
  end

  always_comb begin
    hz.pc_write    = 1'b1;
    hz.ifid_write  = 1'b1;
    hz.ifid_flush  = 1'b0;
    hz.idex_bubble = 1'b0;
    hz.idex_hold   = 1'b0;
    hz.exmem_hold  = 1'b0;
    if (!rst_n) begin
      hz.pc_write    = 1'b0;
      hz.ifid_write  = 1'b0;
      hz.ifid_flush  = 1'b1;
      hz.idex_bubble = 1'b1;
    end else if (hz.dmem_busy) begin
      hz.pc_write   = 1'b0;
      hz.ifid_write = 1'b0;
      hz.idex_hold  = 1'b1;
      hz.exmem_hold = 1'b1;
    end else begin
      case (state)
        RUN: begin
          if (hz.branch_taken) begin
            hz.ifid_flush  = 1'b1;
            hz.idex_bubble = 1'b1;
          end else if (lu_hz) begin
            hz.pc_write    = 1'b0;
            hz.ifid_write  = 1'b0;
            hz.idex_bubble = 1'b1;
          end
        end
        LU_STALL: begin
          if (hz.branch_taken) begin
            hz.ifid_flush  = 1'b1;
            hz.idex_bubble = 1'b1;
          end else begin
            hz.pc_write    = 1'b0;
            hz.ifid_write  = 1'b0;
            hz.idex_bubble = 1'b1;
          end
        end
        FLUSH: begin
          hz.ifid_flush  = 1'b1;
          hz.idex_bubble = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!hz.pc_write && (stall_cnt != {CW{1'b1}})) stall_cnt <= stall_cnt + CW'(1);
      if (hz.ifid_flush && (flush_cnt != {CW{1'b1}})) flush_cnt <= flush_cnt + CW'(1);
    end
  end

endmodule
